// File: rtl/lrn_window_engine.sv
// lrn_window_engine
//   Consumer side of the LRN mapper's GLB read stream. Loads one spatial
//   position's dim3 channel values (and their squares) into local buffers,
//   then walks the channels one at a time, handing the divider the numerator
//   x[c] and the denominator BIAS_K + (cross-channel sum of squares >> ALPHA_SHIFT).
//   The window sum slides with the channel index, so each issue costs one add
//   and one subtract instead of a full re-summation.
//
// Ports
//   core_clk, reset       clock; asynchronous active-high reset
//   start, dim3           begin a layer, dim3 = channels per window
//   rd_valid, rd_data     GLB read stream, channel order 0..dim3-1
//   full_flag             window loaded, held until the window finishes
//   div_num, div_den      divider operands, valid with div_in_valid
//   div_in_valid/ready    divider input handshake
//   div_out_valid         divider finished the current channel
//   normalized_window     one-cycle pulse when every channel has returned
//   cfg_err               sticky: start seen with dim3 == 0 or dim3 > DEPTH
//   overflow_err          sticky: rd_valid arrived while not filling
module lrn_window_engine #(
  parameter int M_WIDTH     = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 64,
  parameter int LOCAL_N     = 2,
  parameter int SUM_WIDTH   = 2*DATA_WIDTH+4,
  parameter int ALPHA_SHIFT = 0,
  parameter int BIAS_K      = 0
) (
  input  logic                  core_clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [M_WIDTH-1:0]    dim3,
  input  logic                  rd_valid,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full_flag,
  output logic [DATA_WIDTH-1:0] div_num,
  output logic [SUM_WIDTH-1:0]  div_den,
  output logic                  div_in_valid,
  input  logic                  div_in_ready,
  input  logic                  div_out_valid,
  output logic                  normalized_window,
  output logic                  cfg_err,
  output logic                  overflow_err
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SQ_W = 2*DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, FILL, PRIME, ISSUE, WAIT_DIV, DONE} state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] x_buf  [DEPTH];
  logic [SQ_W-1:0]       sq_buf [DEPTH];

  logic [M_WIDTH-1:0]   dim3_r, dim3_m1, wr_ptr, ch, prime_last;
  logic [SUM_WIDTH-1:0] sum, add_term, sub_term;
  logic [M_WIDTH:0]     add_idx;
  logic [AW-1:0]        add_addr, sub_addr;
  logic                 start_ok, last_wr, add_ok, sub_ok;

  function automatic logic [SQ_W-1:0] square(input logic [DATA_WIDTH-1:0] x);
    logic [SQ_W-1:0] xe;
    xe = SQ_W'(x);
    return xe * xe;
  endfunction

  function automatic logic [SUM_WIDTH-1:0] calc_den(input logic [SUM_WIDTH-1:0] s);
    return SUM_WIDTH'(BIAS_K) + (s >> ALPHA_SHIFT);
  endfunction

  assign start_ok   = (dim3 != '0) && (dim3 <= M_WIDTH'(DEPTH));
  assign dim3_m1    = dim3_r - 1'b1;
  assign last_wr    = (state == FILL) && rd_valid && (wr_ptr == dim3_m1);
  // Priming loads channels 0..min(LOCAL_N, dim3-1): the window of channel 0.
  assign prime_last = (dim3_m1 < M_WIDTH'(LOCAL_N)) ? dim3_m1 : M_WIDTH'(LOCAL_N);

  // Sliding window: moving from ch to ch+1 brings in ch+LOCAL_N+1 and drops ch-LOCAL_N.
  assign add_idx  = {1'b0, ch} + (M_WIDTH+1)'(LOCAL_N+1);
  assign add_ok   = add_idx < {1'b0, dim3_r};
  assign add_addr = ch[AW-1:0] + AW'(LOCAL_N+1);
  assign sub_ok   = ch >= M_WIDTH'(LOCAL_N);
  assign sub_addr = ch[AW-1:0] - AW'(LOCAL_N);
  assign add_term = add_ok ? SUM_WIDTH'(sq_buf[add_addr]) : '0;
  assign sub_term = sub_ok ? SUM_WIDTH'(sq_buf[sub_addr]) : '0;

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = start_ok ? FILL : IDLE;
    end else begin
      case (state)
        IDLE:     state_nxt = IDLE;
        FILL:     if (last_wr) state_nxt = PRIME;
        PRIME:    if (wr_ptr == prime_last) state_nxt = ISSUE;
        ISSUE:    if (div_in_ready) state_nxt = WAIT_DIV;
        WAIT_DIV: if (div_out_valid) state_nxt = (ch == dim3_m1) ? DONE : ISSUE;
        DONE:     state_nxt = FILL;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // Operands are forced to zero outside ISSUE so the buffers' unreset
  // contents never reach the pins.
  always_comb begin
    div_in_valid      = (state == ISSUE);
    div_num           = '0;
    div_den           = '0;
    normalized_window = (state == DONE);
    if (state == ISSUE) begin
      div_num = x_buf[ch[AW-1:0]];
      div_den = calc_den(sum);
    end
  end

  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      dim3_r       <= '0;
      wr_ptr       <= '0;
      ch           <= '0;
      sum          <= '0;
      full_flag    <= 1'b0;
      cfg_err      <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (rd_valid && (state != FILL)) overflow_err <= 1'b1;
      if (start) begin
        if (start_ok) dim3_r <= dim3;
        else          cfg_err <= 1'b1;
        wr_ptr    <= '0;
        ch        <= '0;
        sum       <= '0;
        full_flag <= 1'b0;
      end else begin
        case (state)
          FILL: if (rd_valid) begin
            if (last_wr) begin
              wr_ptr    <= '0;
              full_flag <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
          PRIME: begin
            sum <= sum + SUM_WIDTH'(sq_buf[wr_ptr[AW-1:0]]);
            if (wr_ptr == prime_last) begin
              wr_ptr <= '0;
              ch     <= '0;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
          ISSUE: if (div_in_ready) sum <= sum + add_term - sub_term;
          WAIT_DIV: if (div_out_valid) begin
            if (ch == dim3_m1) full_flag <= 1'b0;
            else               ch <= ch + 1'b1;
          end
          DONE: begin
            sum    <= '0;
            wr_ptr <= '0;
            ch     <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  // Window storage: datapath only, no reset; squares are formed on the way in.
  always_ff @(posedge core_clk) begin
    if ((state == FILL) && rd_valid && !start) begin
      x_buf[wr_ptr[AW-1:0]]  <= rd_data;
      sq_buf[wr_ptr[AW-1:0]] <= square(rd_data);
    end
  end

endmodule

// File: tb/tb_lrn_window_engine.sv
module tb_lrn_window_engine;
  localparam int MW    = 10;
  localparam int DW    = 16;
  localparam int DEPTH = 64;
  localparam int LN    = 1;
  localparam int SW    = 2*DW+4;

  logic core_clk = 1'b0;
  logic reset, start, rd_valid, div_in_ready, div_out_valid;
  logic [MW-1:0] dim3;
  logic [DW-1:0] rd_data;

  logic          full_a, vld_a, norm_a, cfg_a, ovf_a;
  logic [DW-1:0] num_a;
  logic [SW-1:0] den_a;
  logic          full_b, vld_b, norm_b, cfg_b, ovf_b;
  logic [DW-1:0] num_b;
  logic [SW-1:0] den_b;

  always #5 core_clk = ~core_clk;

  lrn_window_engine #(.M_WIDTH(MW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .LOCAL_N(LN),
                      .SUM_WIDTH(SW), .ALPHA_SHIFT(0), .BIAS_K(0)) dut_a (
    .core_clk(core_clk), .reset(reset), .start(start), .dim3(dim3),
    .rd_valid(rd_valid), .rd_data(rd_data), .full_flag(full_a),
    .div_num(num_a), .div_den(den_a), .div_in_valid(vld_a),
    .div_in_ready(div_in_ready), .div_out_valid(div_out_valid),
    .normalized_window(norm_a), .cfg_err(cfg_a), .overflow_err(ovf_a));

  lrn_window_engine #(.M_WIDTH(MW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .LOCAL_N(LN),
                      .SUM_WIDTH(SW), .ALPHA_SHIFT(1), .BIAS_K(2)) dut_b (
    .core_clk(core_clk), .reset(reset), .start(start), .dim3(dim3),
    .rd_valid(rd_valid), .rd_data(rd_data), .full_flag(full_b),
    .div_num(num_b), .div_den(den_b), .div_in_valid(vld_b),
    .div_in_ready(div_in_ready), .div_out_valid(div_out_valid),
    .normalized_window(norm_b), .cfg_err(cfg_b), .overflow_err(ovf_b));

  int total = 0;
  int bad   = 0;
  longint win_x [DEPTH];
  bit exp_cfg = 0;
  bit exp_ovf = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: denominator straight from the definition of the clipped window.
  function automatic longint ref_den(input int d, input int c, input int shift, input int bias);
    longint s = 0;
    for (int j = c - LN; j <= c + LN; j++)
      if (j >= 0 && j < d) s += win_x[j] * win_x[j];
    return longint'(bias) + (s >> shift);
  endfunction

  task automatic check_operands(input string tag, input int d, input int c);
    check_val({tag, "_vld"},   64'(vld_a), 64'(1));
    check_val({tag, "_num_a"}, 64'(num_a), 64'(win_x[c]));
    check_val({tag, "_den_a"}, 64'(den_a), 64'(ref_den(d, c, 0, 0)));
    check_val({tag, "_num_b"}, 64'(num_b), 64'(win_x[c]));
    check_val({tag, "_den_b"}, 64'(den_b), 64'(ref_den(d, c, 1, 2)));
  endtask

  task automatic do_start(input int d);
    start = 1'b1;
    dim3  = MW'(d);
    @(negedge core_clk);
    start = 1'b0;
    if (d == 0 || d > DEPTH) exp_cfg = 1;
    check_val("start_cfg_a", 64'(cfg_a), 64'(exp_cfg));
    check_val("start_cfg_b", 64'(cfg_b), 64'(exp_cfg));
    check_val("start_full",  64'(full_a), 64'(0));
  endtask

  // Feeds one window from win_x and serves every channel as the divider.
  // bp_ch gets a fixed 5-cycle stall; abort_ch >= 0 stops right after that
  // channel's handshake (engine left in WAIT_DIV).
  task automatic run_window(input int d, input int max_gap, input int bp_max, input int bp_ch,
                            input int lat_lo, input int lat_hi, input bit ovf_probe,
                            input int abort_ch);
    int w, bp, lat;
    for (int i = 0; i < d; i++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge core_clk);
      rd_valid = 1'b1;
      rd_data  = DW'(win_x[i]);
      @(negedge core_clk);
      rd_valid = 1'b0;
      if (i < d - 1) check_val("fill_full", 64'(full_a), 64'(0));
    end
    check_val("full_flag", 64'(full_a), 64'(1));
    for (int c = 0; c < d; c++) begin
      w = 0;
      while (!vld_a && w < 200) begin
        @(negedge core_clk);
        w++;
      end
      if (!vld_a) begin
        check_val("issue_timeout", 64'(vld_a), 64'(1));
        return;
      end
      if (c == 0) check_val("prime_lat", 64'(w), 64'(((LN < d - 1) ? LN : d - 1) + 1));
      check_operands("issue", d, c);
      bp = (c == bp_ch) ? 5 : int'($urandom_range(0, bp_max));
      if (ovf_probe && c == 1 && bp == 0) bp = 1;
      if (bp > 0) begin
        div_in_ready = 1'b0;
        for (int k = 0; k < bp; k++) begin
          if (ovf_probe && c == 1 && k == 0) begin
            rd_valid = 1'b1;
            rd_data  = DW'($urandom);
            exp_ovf  = 1;
          end
          @(negedge core_clk);
          rd_valid = 1'b0;
          check_operands("hold", d, c);
        end
      end
      div_in_ready = 1'b1;
      @(negedge core_clk);
      check_val("wait_vld", 64'(vld_a), 64'(0));
      if (c == abort_ch) return;
      lat = int'($urandom_range(lat_lo, lat_hi));
      repeat (lat) @(negedge core_clk);
      div_out_valid = 1'b1;
      @(negedge core_clk);
      div_out_valid = 1'b0;
    end
    check_val("norm_pulse_a", 64'(norm_a), 64'(1));
    check_val("norm_pulse_b", 64'(norm_b), 64'(1));
    check_val("done_full",    64'(full_a), 64'(0));
    @(negedge core_clk);
    check_val("norm_end", 64'(norm_a), 64'(0));
    check_val("ovf_a", 64'(ovf_a), 64'(exp_ovf));
    check_val("ovf_b", 64'(ovf_b), 64'(exp_ovf));
  endtask

  task automatic set_win(input int d, input int maxv);
    for (int i = 0; i < d; i++) win_x[i] = longint'($urandom_range(0, maxv));
  endtask

  initial begin
    int d;
    reset = 1'b1; start = 1'b0; dim3 = '0; rd_valid = 1'b0; rd_data = '0;
    div_in_ready = 1'b1; div_out_valid = 1'b0;
    repeat (2) @(negedge core_clk);
    check_val("rst_full", 64'(full_a), 64'(0));
    check_val("rst_vld",  64'(vld_a),  64'(0));
    check_val("rst_num",  64'(num_a),  64'(0));
    check_val("rst_den",  64'(den_a),  64'(0));
    check_val("rst_norm", 64'(norm_a), 64'(0));
    check_val("rst_cfg",  64'(cfg_a),  64'(0));
    check_val("rst_ovf",  64'(ovf_a),  64'(0));
    reset = 1'b0;
    @(negedge core_clk);

    // Basic window 1,2,3,4 with a 5-cycle stall on channel 2.
    for (int i = 0; i < 4; i++) win_x[i] = i + 1;
    check_val("ref_basic_den2", 64'(ref_den(4, 2, 0, 0)), 64'(29));
    do_start(4);
    run_window(4, 0, 0, 2, 1, 1, 0, -1);

    // Back-to-back window 4,3,2,1 (no start), with a stray rd_valid during ISSUE.
    for (int i = 0; i < 4; i++) win_x[i] = 4 - i;
    run_window(4, 0, 0, -1, 1, 1, 1, -1);

    // Restart from FILL with a single-channel window.
    win_x[0] = 7;
    do_start(1);
    run_window(1, 0, 0, -1, 0, 2, 0, -1);

    // Bad dim3: error flag, no window.
    do_start(0);
    repeat (3) @(negedge core_clk);
    check_val("cfg0_full", 64'(full_a), 64'(0));
    do_start(DEPTH + 1);
    repeat (3) @(negedge core_clk);
    check_val("cfg65_full", 64'(full_a), 64'(0));
    check_val("cfg65_vld",  64'(vld_a),  64'(0));

    // Randomized windows, two back to back per start.
    for (int r = 0; r < 6; r++) begin
      d = (r == 5) ? DEPTH : int'($urandom_range(1, 16));
      set_win(d, 65535);
      do_start(d);
      run_window(d, 2, 3, -1, 0, 3, 0, -1);
      set_win(d, 65535);
      run_window(d, 1, 2, -1, 0, 2, 0, -1);
    end

    // Asynchronous reset while waiting on the divider.
    set_win(4, 100);
    do_start(4);
    run_window(4, 0, 0, -1, 0, 0, 0, 1);
    #2 reset = 1'b1;
    #1;
    check_val("arst_full", 64'(full_a), 64'(0));
    check_val("arst_vld",  64'(vld_a),  64'(0));
    check_val("arst_num",  64'(num_a),  64'(0));
    check_val("arst_cfg",  64'(cfg_a),  64'(0));
    check_val("arst_ovf",  64'(ovf_a),  64'(0));
    check_val("arst_norm", 64'(norm_a), 64'(0));
    exp_cfg = 0;
    exp_ovf = 0;
    @(negedge core_clk);
    reset = 1'b0;
    @(negedge core_clk);
    set_win(5, 65535);
    do_start(5);
    run_window(5, 1, 2, -1, 0, 2, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=%0d", total, 0);
    $fatal(1, "timeout");
  end

endmodule
